// File: rtl/key_pkg.sv
// Shared FSM encoding and 50 MHz default timing for the key auto-repeat block.
package key_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_IDLE    = 2'd0;
  localparam key_state_t ST_HOLD    = 2'd1;
  localparam key_state_t ST_REPEAT  = 2'd2;
  localparam key_state_t ST_LATCHED = 2'd3;

  // 20 ms debounce, 500 ms long-press, 100 ms repeat period at 50 MHz
  localparam int unsigned KEY_DEB_CYC_50M  = 1_000_000;
  localparam int unsigned KEY_HOLD_CYC_50M = 25_000_000;
  localparam int unsigned KEY_REP_CYC_50M  = 5_000_000;

endpackage

// File: rtl/key_debounce.sv
// 2-flop synchronizer plus stability-counter debounce; o_rise/o_fall are high
// on the cycle before o_level changes, so a registered consumer lines up with it.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC    = KEY_DEB_CYC_50M,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CNT_W = $clog2(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_inv;
  logic             w_key;
  logic             w_diff;
  logic             w_done;

  assign w_inv  = (ACTIVE_LOW != 0);
  assign w_key  = r_sync[1] ^ w_inv;
  assign w_diff = (w_key != r_level);
  assign w_done = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_button};
      if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_done & ~r_level;
  assign o_fall  = w_done & r_level;

endmodule

// File: rtl/key_autorepeat.sv
// Debounced key with press, long-press, auto-repeat and release events.
// All event outputs are registered and coincide with the o_level edge they report.
module key_autorepeat
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC    = KEY_DEB_CYC_50M,
  parameter int unsigned HOLD_CYC   = KEY_HOLD_CYC_50M,
  parameter int unsigned REP_CYC    = KEY_REP_CYC_50M,
  parameter int unsigned REPEAT_EN  = 1,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_level,
  output logic o_pulse,
  output logic o_long,
  output logic o_release
);

  localparam int unsigned TMR_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REP_CYC - 1);

  logic             w_rise;
  logic             w_fall;
  logic             w_rep_en;
  key_state_t       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_pulse;
  logic             r_long;
  logic             r_release;

  assign w_rep_en = (REPEAT_EN != 0);

  key_debounce #(
    .DEB_CYC    (DEB_CYC),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_deb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_button (i_button),
    .o_level  (o_level),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_pulse   <= 1'b0;
      r_long    <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_long    <= 1'b0;
      r_release <= 1'b0;
      // A release beats a timer expiry landing on the same edge.
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_pulse <= 1'b1;
            r_tmr   <= '0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_tmr     <= '0;
            r_state   <= ST_IDLE;
          end else if (r_tmr == HOLD_LAST) begin
            r_long <= 1'b1;
            r_tmr  <= '0;
            if (w_rep_en) begin
              r_pulse <= 1'b1;
              r_state <= ST_REPEAT;
            end else begin
              r_state <= ST_LATCHED;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_tmr     <= '0;
            r_state   <= ST_IDLE;
          end else if (r_tmr == REP_LAST) begin
            r_pulse <= 1'b1;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_LATCHED: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_tmr     <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_tmr   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pulse   = r_pulse;
  assign o_long    = r_long;
  assign o_release = r_release;

endmodule

// File: tb/tb_key_autorepeat.sv
// Directed bench for key_autorepeat with short timing (DEB=4, HOLD=20, REP=5).
module tb_key_autorepeat;

  logic clk;
  logic rst;
  logic b_main, b_nr, b_al;
  logic lv_main, pu_main, lo_main, re_main;
  logic lv_nr, pu_nr, lo_nr, re_nr;
  logic lv_al, pu_al, lo_al, re_al;

  int n_chk = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_autorepeat #(.DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(5), .REPEAT_EN(1), .ACTIVE_LOW(0)) u_main (
    .i_clk(clk), .i_rst(rst), .i_button(b_main),
    .o_level(lv_main), .o_pulse(pu_main), .o_long(lo_main), .o_release(re_main)
  );

  key_autorepeat #(.DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(5), .REPEAT_EN(0), .ACTIVE_LOW(0)) u_nr (
    .i_clk(clk), .i_rst(rst), .i_button(b_nr),
    .o_level(lv_nr), .o_pulse(pu_nr), .o_long(lo_nr), .o_release(re_nr)
  );

  key_autorepeat #(.DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(5), .REPEAT_EN(1), .ACTIVE_LOW(1)) u_al (
    .i_clk(clk), .i_rst(rst), .i_button(b_al),
    .o_level(lv_al), .o_pulse(pu_al), .o_long(lo_al), .o_release(re_al)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s {level,pulse,long,release} got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Raw button value during cycle n of scenario s (for the active-low unit, 0 = pressed).
  function automatic logic btn(input int s, input int n);
    case (s)
      1: return 1'b1;
      2: return (n < 3);
      3: return (n < 28);
      4: return (n < 60);
      5: return 1'b1;
      6: return !(n < 20);
      default: return 1'b0;
    endcase
  endfunction

  // Hand-derived expected {level,pulse,long,release} after edge n.
  function automatic logic [3:0] exp_vec(input int s, input int n);
    logic lv, pu, lo, re;
    lv = 1'b0; pu = 1'b0; lo = 1'b0; re = 1'b0;
    case (s)
      1: begin
        lv = (n >= 6);
        pu = (n == 6) || (n == 26) || (n == 31) || (n == 36) || (n == 41);
        lo = (n == 26);
      end
      3: begin
        lv = (n >= 6) && (n < 34);
        pu = (n == 6) || (n == 26) || (n == 31);
        lo = (n == 26);
        re = (n == 34);
      end
      4: begin
        lv = (n >= 6) && (n < 66);
        pu = (n == 6);
        lo = (n == 26);
        re = (n == 66);
      end
      5: begin
        lv = ((n >= 6) && (n <= 30)) || (n >= 37);
        pu = (n == 6) || (n == 26) || (n == 37);
        lo = (n == 26);
      end
      6: begin
        lv = (n >= 6) && (n < 26);
        pu = (n == 6);
        re = (n == 26);
      end
      default: ;
    endcase
    return {lv, pu, lo, re};
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    b_main = 1'b0; b_nr = 1'b0; b_al = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic run_scn(input int s, input int ncyc);
    logic [3:0] obs;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      case (s)
        4:       b_nr   = btn(s, n);
        6:       b_al   = btn(s, n);
        default: b_main = btn(s, n);
      endcase
      rst = (s == 5) && (n == 30);
      @(negedge clk);
      case (s)
        4:       obs = {lv_nr, pu_nr, lo_nr, re_nr};
        6:       obs = {lv_al, pu_al, lo_al, re_al};
        default: obs = {lv_main, pu_main, lo_main, re_main};
      endcase
      chk($sformatf("s%0d_c%0d", s, n), obs, exp_vec(s, n));
    end
  endtask

  initial begin
    rst = 1'b1;
    b_main = 1'b0; b_nr = 1'b0; b_al = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_main", {lv_main, pu_main, lo_main, re_main}, 4'b0000);
    chk("rst_nr",   {lv_nr, pu_nr, lo_nr, re_nr},         4'b0000);
    chk("rst_al",   {lv_al, pu_al, lo_al, re_al},         4'b0000);

    do_reset(); run_scn(1, 46);   // press and hold with repeats
    do_reset(); run_scn(2, 16);   // 3-cycle glitch
    do_reset(); run_scn(3, 46);   // release during repeat
    do_reset(); run_scn(4, 71);   // no repeat: latched until release
    do_reset(); run_scn(5, 46);   // reset mid-hold, re-detect
    do_reset(); run_scn(6, 36);   // active-low; release coincides with hold expiry

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
